// File: rtl/pipe_pkg.sv
// Shared types and defaults for the pipeline controller: FSM state encoding,
// the stage-control bundle and its canned values.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        MWAIT  = 2'd2,
        HALT   = 2'd3
    } pipe_state_e;

    localparam int MEM_TO_DEFAULT = 16;
    localparam int DRAIN_DEFAULT  = 4;
    localparam int TIMEOUT_W      = 6;

    typedef struct packed {
        logic pcEn;
        logic ifIdEn;
        logic idExEn;
        logic exMemEn;
        logic memWbEn;
        logic ifIdFlush;
        logic idExFlush;
    } stage_ctrl_t;

    // Drain cycles reuse the fetch-bubble pattern: hold the PC, feed bubbles into IF/ID.
    localparam stage_ctrl_t CTRL_FREEZE       = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam stage_ctrl_t CTRL_RUN          = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam stage_ctrl_t CTRL_BRANCH       = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam stage_ctrl_t CTRL_LOAD_USE     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam stage_ctrl_t CTRL_FETCH_BUBBLE = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    function automatic logic [TIMEOUT_W-1:0] satIncTimeout(input logic [TIMEOUT_W-1:0] value);
        return (value == '1) ? value : value + TIMEOUT_W'(1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard/stall/flush controller with memory timeout and drained halt.
// Performance counters are built only when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TO = MEM_TO_DEFAULT,
    parameter int CNT_W  = 32,
    parameter int DRAIN  = DRAIN_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fw_stall,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    input  logic             if_busy,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int DRAIN_W = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);
    localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(DRAIN);
    localparam logic [TIMEOUT_W-1:0] MEM_TO_CNT = TIMEOUT_W'(MEM_TO);

    pipe_state_e          state_q, state_d;
    logic                 branchPend_q, branchPend_d;
    logic [TIMEOUT_W-1:0] toCnt_q, toCnt_d;
    logic                 timeout_q, timeout_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;

    stage_ctrl_t ctrl;
    logic        haltedNow;
    logic        flushEvt;
    logic        stallEvt;
    logic        drainDone;

    assign drainDone = (drain_q == DRAIN_LAST);

    always_comb begin
        state_d      = state_q;
        branchPend_d = branchPend_q;
        toCnt_d      = toCnt_q;
        timeout_d    = timeout_q;
        drain_d      = drain_q;
        ctrl         = CTRL_FREEZE;
        haltedNow    = 1'b0;
        flushEvt     = 1'b0;

        case (state_q)
            HALT: begin
                // A branch still in flight during the drain must steer the PC;
                // once drained, everything except halt_req is ignored.
                if (!drainDone) begin
                    if (ex_branch_taken) begin
                        ctrl     = CTRL_BRANCH;
                        flushEvt = 1'b1;
                    end else begin
                        ctrl = CTRL_FETCH_BUBBLE;
                    end
                    drain_d = drain_q + DRAIN_W'(1);
                end else begin
                    haltedNow = 1'b1;
                end
                if (!halt_req) begin
                    state_d = RUN;
                    drain_d = '0;
                end
            end
            default: begin
                if (mem_busy) begin
                    state_d = MWAIT;
                    toCnt_d = satIncTimeout(toCnt_q);
                    if (toCnt_d >= MEM_TO_CNT) begin
                        timeout_d = 1'b1;
                    end
                    if (ex_branch_taken) begin
                        branchPend_d = 1'b1;
                    end
                end else begin
                    // Leaving MWAIT is resolved with the same priorities as RUN.
                    toCnt_d = '0;
                    if (ex_branch_taken || branchPend_q) begin
                        ctrl         = CTRL_BRANCH;
                        flushEvt     = 1'b1;
                        branchPend_d = 1'b0;
                        state_d      = RUN;
                    end else if (state_q == LSTALL) begin
                        ctrl    = CTRL_RUN;
                        state_d = RUN;
                    end else if (fw_stall) begin
                        ctrl    = CTRL_LOAD_USE;
                        state_d = LSTALL;
                    end else if (if_busy) begin
                        ctrl    = CTRL_FETCH_BUBBLE;
                        state_d = RUN;
                    end else if (halt_req) begin
                        ctrl    = CTRL_RUN;
                        state_d = HALT;
                        drain_d = '0;
                    end else begin
                        ctrl    = CTRL_RUN;
                        state_d = RUN;
                    end
                end
            end
        endcase

        if (reset) begin
            ctrl      = CTRL_FREEZE;
            haltedNow = 1'b0;
            flushEvt  = 1'b0;
        end
    end

    assign stallEvt = !ctrl.pcEn && !haltedNow && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            branchPend_q <= 1'b0;
            toCnt_q      <= '0;
            timeout_q    <= 1'b0;
            drain_q      <= '0;
        end else begin
            state_q      <= state_d;
            branchPend_q <= branchPend_d;
            toCnt_q      <= toCnt_d;
            timeout_q    <= timeout_d;
            drain_q      <= drain_d;
        end
    end

    assign pc_en       = ctrl.pcEn;
    assign if_id_en    = ctrl.ifIdEn;
    assign id_ex_en    = ctrl.idExEn;
    assign ex_mem_en   = ctrl.exMemEn;
    assign mem_wb_en   = ctrl.memWbEn;
    assign if_id_flush = ctrl.ifIdFlush;
    assign id_ex_flush = ctrl.idExFlush;
    assign halted      = haltedNow;
    assign mem_timeout = timeout_q;

`ifdef PIPELINE_CTRL_PERF_EN
    sat_counter #(.CNT_W(CNT_W)) uStallCnt (
        .clock (clock),
        .reset (reset),
        .inc   (stallEvt),
        .clear (1'b0),
        .count (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
        .clock (clock),
        .reset (reset),
        .inc   (flushEvt),
        .clear (1'b0),
        .count (flush_events)
    );
`else
    logic unusedPerf;
    assign unusedPerf   = stallEvt ^ flushEvt;
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed hazard scenarios followed by
// randomized traffic, checked against a cycle-level behavioural model.
module tb_pipeline_ctrl;

    localparam int TB_MEM_TO = 16;
    localparam int TB_CNT_W  = 4;
    localparam int TB_DRAIN  = 4;
    localparam int CNT_MAX   = (1 << TB_CNT_W) - 1;
`ifdef PIPELINE_CTRL_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // Control vector order: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    localparam logic [6:0] V_FREEZE = 7'b0000000;
    localparam logic [6:0] V_RUN    = 7'b1111100;
    localparam logic [6:0] V_BRANCH = 7'b1111111;
    localparam logic [6:0] V_LDUSE  = 7'b0011101;
    localparam logic [6:0] V_BUBBLE = 7'b0111110;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic fw_stall = 1'b0, ex_branch_taken = 1'b0, mem_busy = 1'b0, if_busy = 1'b0, halt_req = 1'b0;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
    logic halted, mem_timeout;
    logic [TB_CNT_W-1:0] stall_cycles, flush_events;

    always #5 clock = ~clock;

    pipeline_ctrl #(
        .MEM_TO (TB_MEM_TO),
        .CNT_W  (TB_CNT_W),
        .DRAIN  (TB_DRAIN)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .fw_stall        (fw_stall),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .if_busy         (if_busy),
        .halt_req        (halt_req),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .halted          (halted),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    typedef struct {
        int                  cyc;
        logic [6:0]          ctrl;
        logic                halted;
        logic                tmo;
        logic [TB_CNT_W-1:0] stalls;
        logic [TB_CNT_W-1:0] flushes;
    } exp_t;

    exp_t sbQ[$];
    int total = 0;
    int bad   = 0;
    int cycNo = 0;

    // Model of the controller in terms of pending obligations rather than states
    bit mLoadUse  = 1'b0;
    bit mHalting  = 1'b0;
    int mDrained  = 0;
    bit mPend     = 1'b0;
    int mBusyRun  = 0;
    bit mTimeout  = 1'b0;
    int mStalls   = 0;
    int mFlushes  = 0;

    task automatic checkOutput(input string name, input int cyc, input logic [31:0] act, input logic [31:0] expVal);
        total++;
        if (act !== expVal) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, expVal);
        end
    endtask

    // Drive one cycle of inputs, advance the model and queue the expected response.
    task automatic applyStimulus(input bit rst, input bit fw, input bit br, input bit mb, input bit ib, input bit hr);
        exp_t e;
        bit   fev;
        @(negedge clock);
        reset           = rst;
        fw_stall        = fw;
        ex_branch_taken = br;
        mem_busy        = mb;
        if_busy         = ib;
        halt_req        = hr;
        cycNo++;
        fev = 1'b0;
        if (rst) begin
            mLoadUse = 0; mHalting = 0; mDrained = 0; mPend = 0;
            mBusyRun = 0; mTimeout = 0; mStalls = 0; mFlushes = 0;
        end
        e.cyc     = cycNo;
        e.ctrl    = V_FREEZE;
        e.halted  = 1'b0;
        e.tmo     = mTimeout;
        e.stalls  = PERF_ON ? TB_CNT_W'(mStalls) : '0;
        e.flushes = PERF_ON ? TB_CNT_W'(mFlushes) : '0;
        if (!rst) begin
            if (mHalting) begin
                if (mDrained < TB_DRAIN) begin
                    e.ctrl = br ? V_BRANCH : V_BUBBLE;
                    fev    = br;
                    mDrained++;
                end else begin
                    e.halted = 1'b1;
                end
                if (!hr) begin
                    mHalting = 0;
                    mDrained = 0;
                end
                mLoadUse = 0;
            end else if (mb) begin
                if (br) mPend = 1;
                if (mBusyRun < 63) mBusyRun++;
                if (mBusyRun >= TB_MEM_TO) mTimeout = 1;
                mLoadUse = 0;
            end else begin
                mBusyRun = 0;
                if (br || mPend) begin
                    e.ctrl = V_BRANCH;
                    fev = 1'b1;
                    mPend = 0;
                    mLoadUse = 0;
                end else if (mLoadUse) begin
                    e.ctrl = V_RUN;
                    mLoadUse = 0;
                end else if (fw) begin
                    e.ctrl = V_LDUSE;
                    mLoadUse = 1;
                end else if (ib) begin
                    e.ctrl = V_BUBBLE;
                end else begin
                    e.ctrl = V_RUN;
                    if (hr) begin
                        mHalting = 1;
                        mDrained = 0;
                    end
                end
            end
            if (!e.ctrl[6] && !e.halted && mStalls < CNT_MAX) mStalls++;
            if (fev && mFlushes < CNT_MAX) mFlushes++;
        end
        sbQ.push_back(e);
    endtask

    // Monitor: every cycle presents a response; compare just before the rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #4;
            if (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                checkOutput("ctrl", e.cyc,
                    32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}), 32'(e.ctrl));
                checkOutput("halted", e.cyc, 32'(halted), 32'(e.halted));
                checkOutput("mem_timeout", e.cyc, 32'(mem_timeout), 32'(e.tmo));
                checkOutput("stall_cycles", e.cyc, 32'(stall_cycles), 32'(e.stalls));
                checkOutput("flush_events", e.cyc, 32'(flush_events), 32'(e.flushes));
            end
        end
    end

    initial begin
        int busyLeft;
        int haltLeft;
        bit rst, fw, br, mb, ib, hr;
        busyLeft = 0;
        haltLeft = 0;

        $display("[TB] start");
        repeat (2) applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // load-use stall then its shadow cycle
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // branch beats load-use
        applyStimulus(0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // branch arriving under memory wait is replayed on release
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // fetch bubbles, and if_busy ignored in the load-use shadow
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        // long memory stall trips the sticky timeout
        repeat (20) applyStimulus(0, 0, 0, 1, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

        // reset in the middle of a wait with a pending branch
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);

        // full drain and halt, inputs ignored while halted, then resume
        repeat (6) applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // branch mid-drain, then early exit mid-drain
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 900; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            if (busyLeft == 0 && $urandom_range(0, 9) == 0)
                busyLeft = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 22)) : int'($urandom_range(1, 4));
            mb = (busyLeft > 0);
            if (busyLeft > 0) busyLeft--;
            if (haltLeft == 0 && $urandom_range(0, 39) == 0)
                haltLeft = int'($urandom_range(1, 12));
            hr = (haltLeft > 0);
            if (haltLeft > 0) haltLeft--;
            fw = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 7) == 0);
            ib = ($urandom_range(0, 5) == 0);
            applyStimulus(rst, fw, br, mb, ib, hr);
        end

        repeat (3) @(negedge clock);
        checkOutput("scoreboard_drained", cycNo, 32'(sbQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
